// File: rtl/apb_cfg_master.sv
// apb_cfg_master: single-command APB master for the TPU config port.
// Optional poll timeout is enabled with `define APB_CFG_POLL_TIMEOUT_EN.
module apb_cfg_master #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int POLL_GAP  = 4,
  parameter int TIMEOUT_W = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [ADDR_W-1:0]    cmd_addr,
  input  logic [DATA_W-1:0]    cmd_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_W-1:0]    rsp_rdata,
  output logic                 rsp_err,
  output logic [TIMEOUT_W-1:0] rsp_polls,
  input  logic [TIMEOUT_W-1:0] timeout_limit,
  output logic [ADDR_W-1:0]    PADDR,
  output logic                 PWRITE,
  output logic                 PSEL,
  output logic                 PENABLE,
  output logic [DATA_W-1:0]    PWDATA,
  input  logic [DATA_W-1:0]    PRDATA,
  input  logic                 PREADY
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_GAP,
    S_RESP
  } state_e;

  localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST =
    GW'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

  state_e                state_q;
  logic                  poll_q;
  logic [DATA_W-1:0]     mask_q;
  logic [GW-1:0]         gap_q;
  logic [ADDR_W-1:0]     paddr_q;
  logic                  pwrite_q;
  logic                  psel_q;
  logic                  penable_q;
  logic [DATA_W-1:0]     pwdata_q;
  logic                  rsp_valid_q;
  logic [DATA_W-1:0]     rdata_q;
  logic                  err_q;
  logic [TIMEOUT_W-1:0]  polls_q;
  logic [TIMEOUT_W-1:0]  polls_d;
  logic                  hit;
  logic                  tmo;

  // Poll attempt count saturates rather than wrapping
  assign polls_d = (&polls_q) ? polls_q
                              : polls_q + TIMEOUT_W'(1);
  assign hit = (PRDATA & mask_q) != '0;

`ifdef APB_CFG_POLL_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] limit_q;
  // Zero limit means poll forever
  assign tmo = (limit_q != '0) && (polls_d >= limit_q);
`else
  logic unused_limit;
  assign unused_limit = ^timeout_limit;
  assign tmo = 1'b0;
`endif

  assign cmd_ready = (state_q == S_IDLE);
  assign PADDR     = paddr_q;
  assign PWRITE    = pwrite_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign rsp_polls = polls_q;

  // Command FSM with registered APB and response outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      poll_q      <= 1'b0;
      mask_q      <= '0;
      gap_q       <= '0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      polls_q     <= '0;
`ifdef APB_CFG_POLL_TIMEOUT_EN
      limit_q     <= '0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            state_q   <= S_SETUP;
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            paddr_q   <= cmd_addr;
            pwrite_q  <= (cmd_op == 2'b00);
            pwdata_q  <= (cmd_op == 2'b00) ? cmd_wdata : '0;
            poll_q    <= (cmd_op == 2'b10);
            mask_q    <= cmd_wdata;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            polls_q   <= '0;
`ifdef APB_CFG_POLL_TIMEOUT_EN
            limit_q   <= timeout_limit;
`endif
          end
        end
        S_SETUP: begin
          penable_q <= 1'b1;
          state_q   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (PREADY) begin
            penable_q <= 1'b0;
            psel_q    <= 1'b0;
            if (!pwrite_q) rdata_q <= PRDATA;
            if (!poll_q) begin
              rsp_valid_q <= 1'b1;
              state_q     <= S_RESP;
            end else begin
              polls_q <= polls_d;
              if (hit) begin
                rsp_valid_q <= 1'b1;
                state_q     <= S_RESP;
              end else if (tmo) begin
                err_q       <= 1'b1;
                rsp_valid_q <= 1'b1;
                state_q     <= S_RESP;
              end else if (POLL_GAP == 0) begin
                psel_q  <= 1'b1;
                state_q <= S_SETUP;
              end else begin
                gap_q   <= '0;
                state_q <= S_GAP;
              end
            end
          end
        end
        S_GAP: begin
          if (gap_q == GAP_LAST) begin
            psel_q  <= 1'b1;
            state_q <= S_SETUP;
          end else begin
            gap_q <= gap_q + GW'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_cfg_master.sv
// tb_apb_cfg_master: directed bench for apb_cfg_master.
// Behavioural APB slave plus per-scenario tasks.
module tb_apb_cfg_master;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TW = 16;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [TW-1:0] rsp_polls;
  logic [TW-1:0] timeout_limit = '0;
  logic [AW-1:0] PADDR;
  logic          PWRITE;
  logic          PSEL;
  logic          PENABLE;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA = '0;
  logic          PREADY = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] rd_data [16];
  int rd_idx = 0;
  int slv_wait = 0;
  int wcnt = 0;
  int xfer_cnt = 0;
  int idle_run = 0;
  int exp_gap = 4;
  int gap_err = 0;
  logic [AW-1:0] last_addr = '0;
  logic last_write = 1'b0;

  apb_cfg_master dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_polls(rsp_polls),
    .timeout_limit(timeout_limit),
    .PADDR(PADDR), .PWRITE(PWRITE), .PSEL(PSEL),
    .PENABLE(PENABLE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 clk = ~clk;

  // Slave: slv_wait wait states, junk data when not ready
  always @(negedge clk) begin
    if (PSEL && PENABLE) begin
      if (wcnt >= slv_wait) begin
        PREADY = 1'b1;
        PRDATA = rd_data[rd_idx % 16];
      end else begin
        PREADY = 1'b0;
        PRDATA = 32'hFFFF_FFFF;
        wcnt++;
      end
    end else begin
      PREADY = 1'b0;
      PRDATA = 32'hDEAD_BEEF;
      wcnt = 0;
    end
  end

  // Monitor: count transfers and idle gaps between them
  always @(posedge clk) begin
    if (PSEL && PENABLE && PREADY) begin
      xfer_cnt++;
      rd_idx++;
      last_addr = PADDR;
      last_write = PWRITE;
    end
    if (!PSEL) begin
      idle_run++;
    end else if (!PENABLE) begin
      if (xfer_cnt > 0 && idle_run != exp_gap) gap_err++;
      idle_run = 0;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [1:0] op, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [TW-1:0] lim);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_addr = a;
    cmd_wdata = d;
    timeout_limit = lim;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_addr = 8'hFF;
    cmd_wdata = 32'h5A5A_5A5A;
    timeout_limit = 16'd1;
  endtask

  task automatic wait_rsp(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (PSEL !== 1'b0) begin n_bad++;
      $display("FAIL rst_psel got %b want 0", PSEL); end
    n_cmp++; if (PENABLE !== 1'b0) begin n_bad++;
      $display("FAIL rst_penable got %b want 0", PENABLE); end
    n_cmp++; if (PWRITE !== 1'b0) begin n_bad++;
      $display("FAIL rst_pwrite got %b want 0", PWRITE); end
    n_cmp++; if (PADDR !== 8'h00) begin n_bad++;
      $display("FAIL rst_paddr got %h want 00", PADDR); end
    n_cmp++; if (PWDATA !== 32'h0) begin n_bad++;
      $display("FAIL rst_pwdata got %h want 0", PWDATA); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++;
      $display("FAIL rst_rsp_valid got %b want 0", rsp_valid); end
    n_cmp++; if (rsp_rdata !== 32'h0) begin n_bad++;
      $display("FAIL rst_rdata got %h want 0", rsp_rdata); end
    n_cmp++; if (rsp_err !== 1'b0) begin n_bad++;
      $display("FAIL rst_err got %b want 0", rsp_err); end
    n_cmp++; if (rsp_polls !== 16'd0) begin n_bad++;
      $display("FAIL rst_polls got %0d want 0", rsp_polls); end
    resetn = 1'b1;
    @(negedge clk);
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++;
      $display("FAIL rst_cmd_ready got %b want 1", cmd_ready); end
  endtask

  task automatic test_write();
    rd_idx = 0;
    slv_wait = 0;
    rd_data[0] = 32'hAAAA_5555;
    send(2'b00, 8'h00, 32'h0000_000F, 16'd0);
    n_cmp++; if ({PSEL, PENABLE, PWRITE} !== 3'b101) begin n_bad++;
      $display("FAIL wr_setup sel/en/wr got %b want 101",
               {PSEL, PENABLE, PWRITE}); end
    n_cmp++; if (PWDATA !== 32'hF || PADDR !== 8'h00) begin n_bad++;
      $display("FAIL wr_setup_bus got %h/%h want f/00", PWDATA, PADDR); end
    n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++;
      $display("FAIL wr_cmd_ready got %b want 0", cmd_ready); end
    @(negedge clk);
    n_cmp++; if ({PSEL, PENABLE, rsp_valid} !== 3'b110) begin n_bad++;
      $display("FAIL wr_access sel/en/rv got %b want 110",
               {PSEL, PENABLE, rsp_valid}); end
    @(negedge clk);
    n_cmp++; if ({rsp_valid, PSEL, PENABLE} !== 3'b100) begin n_bad++;
      $display("FAIL wr_resp rv/sel/en got %b want 100",
               {rsp_valid, PSEL, PENABLE}); end
    n_cmp++; if (rsp_rdata !== 32'h0) begin n_bad++;
      $display("FAIL wr_rdata got %h want 0", rsp_rdata); end
    handshake();
    n_cmp++; if ({rsp_valid, cmd_ready} !== 2'b01) begin n_bad++;
      $display("FAIL wr_done rv/cr got %b want 01",
               {rsp_valid, cmd_ready}); end
  endtask

  task automatic test_read_wait();
    int acc;
    int unstable;
    bit ok;
    acc = 0;
    unstable = 0;
    rd_idx = 0;
    slv_wait = 2;
    rd_data[0] = 32'h0000_000D;
    send(2'b01, 8'h00, 32'hFFFF_FFFF, 16'd0);
    n_cmp++; if ({PSEL, PENABLE, PWRITE} !== 3'b100) begin n_bad++;
      $display("FAIL rd_setup sel/en/wr got %b want 100",
               {PSEL, PENABLE, PWRITE}); end
    n_cmp++; if (PWDATA !== 32'h0) begin n_bad++;
      $display("FAIL rd_pwdata got %h want 0", PWDATA); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (PSEL && PENABLE) begin
        acc++;
        if (PADDR !== 8'h00 || PWRITE !== 1'b0 || PWDATA !== 32'h0)
          unstable++;
      end else begin
        break;
      end
    end
    ok = rsp_valid;
    n_cmp++; if (acc !== 3) begin n_bad++;
      $display("FAIL rd_access_cycles got %0d want 3", acc); end
    n_cmp++; if (unstable !== 0) begin n_bad++;
      $display("FAIL rd_stable got %0d want 0", unstable); end
    n_cmp++; if (ok !== 1'b1) begin n_bad++;
      $display("FAIL rd_rsp_valid got %b want 1", ok); end
    n_cmp++; if (rsp_rdata !== 32'h0000_000D) begin n_bad++;
      $display("FAIL rd_rdata got %h want d", rsp_rdata); end
    handshake();
    slv_wait = 0;
  endtask

  task automatic test_poll();
    bit ok;
    rd_idx = 0;
    slv_wait = 0;
    exp_gap = 4;
    for (int i = 0; i < 16; i++) rd_data[i] = 32'h0;
    rd_data[3] = 32'h8000_0001;
    xfer_cnt = 0;
    gap_err = 0;
    send(2'b10, 8'h04, 32'h8000_0000, 16'd0);
    wait_rsp(200, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++;
      $display("FAIL poll_rsp got %b want 1", ok); end
    n_cmp++; if (xfer_cnt !== 4) begin n_bad++;
      $display("FAIL poll_xfers got %0d want 4", xfer_cnt); end
    n_cmp++; if (gap_err !== 0) begin n_bad++;
      $display("FAIL poll_gap got %0d bad gaps want 0", gap_err); end
    n_cmp++; if (rsp_polls !== 16'd4) begin n_bad++;
      $display("FAIL poll_count got %0d want 4", rsp_polls); end
    n_cmp++; if (rsp_rdata !== 32'h8000_0001) begin n_bad++;
      $display("FAIL poll_rdata got %h want 80000001", rsp_rdata); end
    n_cmp++; if (rsp_err !== 1'b0) begin n_bad++;
      $display("FAIL poll_err got %b want 0", rsp_err); end
    n_cmp++; if ({last_addr, last_write} !== {8'h04, 1'b0}) begin n_bad++;
      $display("FAIL poll_bus got %h/%b want 04/0", last_addr, last_write);
    end
    handshake();
  endtask

  task automatic test_timeout();
    bit ok;
    rd_idx = 0;
    for (int i = 0; i < 16; i++) rd_data[i] = 32'h0;
    xfer_cnt = 0;
    send(2'b10, 8'h08, 32'h0000_0001, 16'd5);
`ifdef APB_CFG_POLL_TIMEOUT_EN
    wait_rsp(200, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++;
      $display("FAIL tmo_rsp got %b want 1", ok); end
    n_cmp++; if (xfer_cnt !== 5) begin n_bad++;
      $display("FAIL tmo_xfers got %0d want 5", xfer_cnt); end
    n_cmp++; if (rsp_err !== 1'b1) begin n_bad++;
      $display("FAIL tmo_err got %b want 1", rsp_err); end
    n_cmp++; if (rsp_polls !== 16'd5) begin n_bad++;
      $display("FAIL tmo_polls got %0d want 5", rsp_polls); end
    handshake();
`else
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) ok = 1'b1;
    end
    n_cmp++; if (ok !== 1'b0) begin n_bad++;
      $display("FAIL notmo_early_rsp got %b want 0", ok); end
    n_cmp++; if ((xfer_cnt >= 6) !== 1'b1) begin n_bad++;
      $display("FAIL notmo_xfers got %0d want >=6", xfer_cnt); end
    for (int i = 0; i < 16; i++) rd_data[i] = 32'h0000_0001;
    wait_rsp(50, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++;
      $display("FAIL notmo_rsp got %b want 1", ok); end
    n_cmp++; if (rsp_err !== 1'b0) begin n_bad++;
      $display("FAIL notmo_err got %b want 0", rsp_err); end
    n_cmp++; if (rsp_polls !== TW'(xfer_cnt)) begin n_bad++;
      $display("FAIL notmo_polls got %0d want %0d", rsp_polls, xfer_cnt);
    end
    handshake();
`endif
  endtask

  task automatic test_back_to_back();
    bit ok;
    rd_idx = 0;
    rd_data[0] = 32'h1234_5678;
    send(2'b01, 8'h10, 32'h0, 16'd0);
    wait_rsp(20, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++;
      $display("FAIL b2b_rsp got %b want 1", ok); end
    cmd_valid = 1'b1;
    cmd_op = 2'b00;
    cmd_addr = 8'h20;
    cmd_wdata = 32'h0000_CAFE;
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1234_5678 ||
          cmd_ready !== 1'b0 || PSEL !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_c%0d rv/rd/cr/sel got %b/%h/%b/%b want 1/12345678/0/0",
                 i, rsp_valid, rsp_rdata, cmd_ready, PSEL);
      end
      @(negedge clk);
    end
    handshake();
    n_cmp++; if ({rsp_valid, cmd_ready, PSEL} !== 3'b010) begin n_bad++;
      $display("FAIL b2b_idle rv/cr/sel got %b want 010",
               {rsp_valid, cmd_ready, PSEL}); end
    @(negedge clk);
    cmd_valid = 1'b0;
    n_cmp++; if ({PSEL, PENABLE, PWRITE} !== 3'b101) begin n_bad++;
      $display("FAIL b2b_setup sel/en/wr got %b want 101",
               {PSEL, PENABLE, PWRITE}); end
    n_cmp++; if (PADDR !== 8'h20 || PWDATA !== 32'hCAFE) begin n_bad++;
      $display("FAIL b2b_bus got %h/%h want 20/cafe", PADDR, PWDATA); end
    wait_rsp(10, ok);
    n_cmp++; if (ok !== 1'b1 || rsp_rdata !== 32'h0) begin n_bad++;
      $display("FAIL b2b_wr_rsp got %b/%h want 1/0", ok, rsp_rdata); end
    handshake();
  endtask

  task automatic test_reset_mid();
    rd_idx = 0;
    slv_wait = 5;
    send(2'b01, 8'h30, 32'h0, 16'd0);
    @(negedge clk);
    n_cmp++; if ({PSEL, PENABLE} !== 2'b11) begin n_bad++;
      $display("FAIL mid_access got %b want 11", {PSEL, PENABLE}); end
    #2 resetn = 1'b0;
    #1;
    n_cmp++; if ({PSEL, PENABLE, rsp_valid} !== 3'b000) begin n_bad++;
      $display("FAIL mid_async got %b want 000",
               {PSEL, PENABLE, rsp_valid}); end
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if ({rsp_valid, PSEL, cmd_ready} !== 3'b001) begin n_bad++;
      $display("FAIL mid_after rv/sel/cr got %b want 001",
               {rsp_valid, PSEL, cmd_ready}); end
    slv_wait = 0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rd_data[i] = 32'h0;
    test_reset();
    test_write();
    test_read_wait();
    test_poll();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
